// File: rtl/seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// seg7_scan_driver
//
// Multi-digit seven-segment display driver. Holds a packed hex word captured
// on a load strobe and scans its nibbles, one digit at a time, onto a shared
// segment bus. Each digit is driven for REFRESH_DIV clocks per scan slot. The
// driver adds per-digit blanking, leading-zero suppression and a whole-display
// blink whose half-period is BLINK_FRAMES full scan frames.
//
// Ports:
//   clk          system clock
//   rst_n        asynchronous active-low reset
//   load         capture data_in into the display register this cycle
//   data_in      packed hex digits, nibble i = bits [4i+3:4i] (digit 0 = LSN)
//   blank_mask   bit i = 1 forces digit i dark (sampled live)
//   lz_suppress  blank leading zero digits (sampled live)
//   blink_en     enable whole-display blink (sampled live)
//   seg          registered segment bus {g,f,e,d,c,b,a}
//   an           registered one-hot digit enable
//   frame_tick   one-cycle pulse when the scan wraps to digit 0
//
// Polarity: ACTIVE_LOW = 1 drives both seg and an low for "on".
// -----------------------------------------------------------------------------
module seg7_scan_driver #(
  parameter int NUM_DIGITS   = 4,
  parameter int REFRESH_DIV  = 50000,
  parameter int BLINK_FRAMES = 64,
  parameter int ACTIVE_LOW   = 1
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    load,
  input  logic [4*NUM_DIGITS-1:0] data_in,
  input  logic [NUM_DIGITS-1:0]   blank_mask,
  input  logic                    lz_suppress,
  input  logic                    blink_en,
  output logic [6:0]              seg,
  output logic [NUM_DIGITS-1:0]   an,
  output logic                    frame_tick
);

  localparam int CNT_W = (REFRESH_DIV  > 1) ? $clog2(REFRESH_DIV)  : 1;
  localparam int IDX_W = (NUM_DIGITS   > 1) ? $clog2(NUM_DIGITS)   : 1;
  localparam int FRM_W = (BLINK_FRAMES > 1) ? $clog2(BLINK_FRAMES) : 1;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(REFRESH_DIV - 1);
  localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
  localparam logic [FRM_W-1:0] FRM_LAST = FRM_W'(BLINK_FRAMES - 1);

  localparam logic [6:0] SEG_DARK = 7'h00;

  // Hex digit to active-high segment pattern {g,f,e,d,c,b,a}.
  function automatic logic [6:0] hex7(input logic [3:0] nib);
    logic [6:0] pat;
    case (nib)
      4'h0:    pat = 7'b0111111;
      4'h1:    pat = 7'b0000110;
      4'h2:    pat = 7'b1011011;
      4'h3:    pat = 7'b1001111;
      4'h4:    pat = 7'b1100110;
      4'h5:    pat = 7'b1101101;
      4'h6:    pat = 7'b1111101;
      4'h7:    pat = 7'b0000111;
      4'h8:    pat = 7'b1111111;
      4'h9:    pat = 7'b1101111;
      4'hA:    pat = 7'b1110111;
      4'hB:    pat = 7'b1111100;
      4'hC:    pat = 7'b0111001;
      4'hD:    pat = 7'b1011110;
      4'hE:    pat = 7'b1111001;
      default: pat = 7'b1110001;
    endcase
    return pat;
  endfunction

  // Map active-high segment intent onto the board's pin polarity.
  function automatic logic [6:0] seg_level(input logic [6:0] on);
    return (ACTIVE_LOW != 0) ? ~on : on;
  endfunction

  // Map active-high digit-enable intent onto the board's pin polarity.
  function automatic logic [NUM_DIGITS-1:0] an_level(input logic [NUM_DIGITS-1:0] on);
    return (ACTIVE_LOW != 0) ? ~on : on;
  endfunction

  // ---------------------------------------------------------------------------
  // Stage p0: display register, scan timing and blink state
  // ---------------------------------------------------------------------------
  logic [4*NUM_DIGITS-1:0] disp_p0;
  logic [CNT_W-1:0]        refresh_cnt_p0;
  logic [IDX_W-1:0]        idx_p0;
  logic [FRM_W-1:0]        frame_cnt_p0;
  logic                    hidden_p0;

  logic slot_end_p0;
  logic frame_end_p0;

  assign slot_end_p0  = (refresh_cnt_p0 == CNT_LAST);
  assign frame_end_p0 = slot_end_p0 && (idx_p0 == IDX_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      disp_p0        <= '0;
      refresh_cnt_p0 <= '0;
      idx_p0         <= '0;
      frame_cnt_p0   <= '0;
      hidden_p0      <= 1'b0;
    end else begin
      // A load coinciding with a slot advance is fine: the next digit is
      // decoded from the freshly loaded word on the following cycle.
      if (load) begin
        disp_p0 <= data_in;
      end

      if (slot_end_p0) begin
        refresh_cnt_p0 <= '0;
        idx_p0         <= (idx_p0 == IDX_LAST) ? '0 : idx_p0 + IDX_W'(1);
      end else begin
        refresh_cnt_p0 <= refresh_cnt_p0 + CNT_W'(1);
      end

      // Blink phase keeps running even while blink_en is low, so enabling
      // blink later does not restart the rhythm.
      if (frame_end_p0) begin
        if (frame_cnt_p0 == FRM_LAST) begin
          frame_cnt_p0 <= '0;
          hidden_p0    <= ~hidden_p0;
        end else begin
          frame_cnt_p0 <= frame_cnt_p0 + FRM_W'(1);
        end
      end
    end
  end

  // Select the current digit and work out whether it is a leading zero.
  // Walking from the top digit down, lz_run stays set while every nibble
  // seen so far (including this one) is zero.
  logic [3:0]            nibble_p0;
  logic                  mask_sel_p0;
  logic                  lz_sel_p0;
  logic                  lz_run_p0;
  logic [NUM_DIGITS-1:0] an_hot_p0;
  logic                  blank_p0;

  always_comb begin
    nibble_p0   = 4'h0;
    mask_sel_p0 = 1'b0;
    lz_sel_p0   = 1'b0;
    lz_run_p0   = 1'b1;
    an_hot_p0   = '0;
    for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
      lz_run_p0 = lz_run_p0 & (disp_p0[4*i +: 4] == 4'h0);
      if (idx_p0 == IDX_W'(i)) begin
        nibble_p0    = disp_p0[4*i +: 4];
        mask_sel_p0  = blank_mask[i];
        // Digit 0 always shows, so a zero value displays a single "0".
        lz_sel_p0    = lz_run_p0 && (i != 0);
        an_hot_p0[i] = 1'b1;
      end
    end
  end

  assign blank_p0 = mask_sel_p0
                  | (lz_suppress & lz_sel_p0)
                  | (blink_en & hidden_p0);

  // ---------------------------------------------------------------------------
  // Stage p1: registered pin drive
  // ---------------------------------------------------------------------------
  // The digit enable stays asserted on blank digits; only the segments go dark.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      seg        <= seg_level(SEG_DARK);
      an         <= an_level('0);
      frame_tick <= 1'b0;
    end else begin
      seg        <= seg_level(blank_p0 ? SEG_DARK : hex7(nibble_p0));
      an         <= an_level(an_hot_p0);
      frame_tick <= frame_end_p0;
    end
  end

endmodule

// File: tb/tb_seg7_scan_driver.sv
// -----------------------------------------------------------------------------
// tb_seg7_scan_driver
//
// Scoreboard bench for seg7_scan_driver (4 digits, 4-cycle slots, 2-frame
// blink half-period, active-low pins). The driver predicts each clock's pin
// state from elapsed-cycle arithmetic and pushes it into a queue; a monitor
// pops and compares one entry per clock after the active edge.
// -----------------------------------------------------------------------------
module tb_seg7_scan_driver;

  localparam int N  = 4;
  localparam int R  = 4;
  localparam int BF = 2;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          load;
  logic [15:0]   data_in;
  logic [3:0]    blank_mask;
  logic          lz_suppress;
  logic          blink_en;
  logic [6:0]    seg;
  logic [3:0]    an;
  logic          frame_tick;

  seg7_scan_driver #(
    .NUM_DIGITS  (N),
    .REFRESH_DIV (R),
    .BLINK_FRAMES(BF),
    .ACTIVE_LOW  (1)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .load       (load),
    .data_in    (data_in),
    .blank_mask (blank_mask),
    .lz_suppress(lz_suppress),
    .blink_en   (blink_en),
    .seg        (seg),
    .an         (an),
    .frame_tick (frame_tick)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [6:0] seg;
    logic [3:0] an;
    logic       ft;
  } exp_t;

  exp_t q[$];

  logic [6:0] hex_tab [16] = '{
    7'b0111111, 7'b0000110, 7'b1011011, 7'b1001111,
    7'b1100110, 7'b1101101, 7'b1111101, 7'b0000111,
    7'b1111111, 7'b1101111, 7'b1110111, 7'b1111100,
    7'b0111001, 7'b1011110, 7'b1111001, 7'b1110001
  };

  int          checks = 0;
  int          passed = 0;
  int unsigned n      = 0;      // clock edges since reset release
  logic [15:0] disp_m = '0;     // modelled display register

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] req);
    checks++;
    if (act === req) passed++;
    else $display("FAIL %s: got %h, expected %h (t=%0t)", name, act, req, $time);
  endtask

  // Pin state after the next edge, given n edges already elapsed, the
  // display word held before that edge and the live control inputs.
  function automatic exp_t model(input int unsigned cyc, input logic [15:0] d,
                                 input logic [3:0] mk, input logic lz, input logic bl);
    exp_t        e;
    int unsigned idx;
    int unsigned frames;
    logic        hidden;
    logic [3:0]  nib;
    logic        blank;
    idx    = (cyc / R) % N;
    frames = cyc / (R * N);
    hidden = ((frames / BF) % 2) == 1;
    nib    = 4'((d >> (4 * idx)) & 16'hF);
    blank  = mk[idx] || (lz && idx > 0 && ((d >> (4 * idx)) == 16'h0)) || (bl && hidden);
    e.seg  = blank ? 7'h7F : ~hex_tab[nib];
    e.an   = ~(4'b0001 << idx);
    e.ft   = ((cyc + 1) % (R * N)) == 0;
    return e;
  endfunction

  // Called at a negedge; drives one clock of inputs and predicts its outcome.
  task automatic step(input logic ld, input logic [15:0] d, input logic [3:0] mk,
                      input logic lz, input logic bl);
    load        = ld;
    data_in     = d;
    blank_mask  = mk;
    lz_suppress = lz;
    blink_en    = bl;
    q.push_back(model(n, disp_m, mk, lz, bl));
    if (ld) disp_m = d;
    n++;
    @(posedge clk);
    @(negedge clk);
  endtask

  task automatic run(input int k, input logic [3:0] mk, input logic lz, input logic bl);
    for (int i = 0; i < k; i++) step(1'b0, 16'h0, mk, lz, bl);
  endtask

  // Asynchronous reset in the middle of a clock period and of a scan slot.
  task automatic mid_reset();
    load = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    chk("async_rst_seg", {9'h0, seg}, 16'h007F);
    chk("async_rst_an", {12'h0, an}, 16'h000F);
    chk("async_rst_ft", {15'h0, frame_tick}, 16'h0000);
    repeat (3) @(negedge clk);
    chk("held_rst_seg", {9'h0, seg}, 16'h007F);
    rst_n  = 1'b1;
    n      = 0;
    disp_m = '0;
  endtask

  // Monitor: one expected entry per clock while out of reset.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("seg", {9'h0, seg}, {9'h0, e.seg});
        chk("an", {12'h0, an}, {12'h0, e.an});
        chk("frame_tick", {15'h0, frame_tick}, {15'h0, e.ft});
      end
    end
  end

  initial begin
    logic [15:0] d;
    rst_n = 1'b0;
    load = 1'b0; data_in = '0; blank_mask = '0; lz_suppress = 1'b0; blink_en = 1'b0;
    repeat (3) @(negedge clk);
    chk("reset_seg", {9'h0, seg}, 16'h007F);
    chk("reset_an", {12'h0, an}, 16'h000F);
    chk("reset_ft", {15'h0, frame_tick}, 16'h0000);
    rst_n = 1'b1;

    // Basic scan of 12AF over two frames.
    step(1'b1, 16'h12AF, 4'b0000, 1'b0, 1'b0);
    run(32, 4'b0000, 1'b0, 1'b0);

    // Leading-zero suppression, including an all-zero value.
    step(1'b1, 16'h0007, 4'b0000, 1'b1, 1'b0);
    run(20, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 16'h0000, 4'b0000, 1'b1, 1'b0);
    run(20, 4'b0000, 1'b1, 1'b0);
    step(1'b1, 16'h0A00, 4'b0000, 1'b1, 1'b0);
    run(16, 4'b0000, 1'b1, 1'b0);

    // Per-digit blanking.
    step(1'b1, 16'h8888, 4'b0100, 1'b0, 1'b0);
    run(20, 4'b0100, 1'b0, 1'b0);

    // Blink enabled across several half-periods, then disabled.
    run(100, 4'b0000, 1'b0, 1'b1);
    run(70, 4'b0000, 1'b0, 1'b0);

    // Load exactly on a slot-advance edge.
    while ((n % R) != (R - 1)) step(1'b0, 16'h0, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 16'h3C5E, 4'b0000, 1'b0, 1'b0);
    run(8, 4'b0000, 1'b0, 1'b0);

    // Asynchronous reset mid-slot, then scan restarts from digit 0.
    while ((n % R) != 2) step(1'b0, 16'h0, 4'b0000, 1'b0, 1'b0);
    mid_reset();
    run(20, 4'b0000, 1'b0, 1'b0);
    step(1'b1, 16'h4D69, 4'b0000, 1'b0, 1'b0);
    run(40, 4'b0000, 1'b0, 1'b1);

    // Randomised traffic.
    for (int i = 0; i < 900; i++) begin
      d = 16'($urandom) >> (4 * $urandom_range(0, 4));
      step(($urandom_range(0, 3) == 0), d,
           ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000,
           1'($urandom), ($urandom_range(0, 1) == 0));
    end

    @(posedge clk);
    #3;
    chk("queue_drained", 16'(q.size()), 16'h0000);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule

// File: doc/seg7_scan_driver.md
Name: seg7_scan_driver

Overview:
- Parametrised multi-digit seven-segment display driver. Successor to the single-digit nibble-to-segment path.
- Latches a packed hex word on a load strobe and time-multiplexes its nibbles onto one shared segment bus with one-hot digit enables.
- Adds per-digit blanking, leading-zero suppression and whole-display blink.
- Sits between datapath result registers and the board's common-anode/common-cathode display pins.

Parameters:
NUM_DIGITS, 4, number of display digits (1..8); digit 0 = least significant nibble.
REFRESH_DIV, 50000, clock cycles each digit is driven per scan slot (>=2).
BLINK_FRAMES, 64, full scan frames per blink half-period (>=1).
ACTIVE_LOW, 1, 1 = seg and an asserted low; 0 = asserted high.

Ports:
clk  in  1  system clock
rst_n  in  1  asynchronous active-low reset
load  in  1  capture data_in into display register this cycle
data_in  in  4*NUM_DIGITS  packed hex digits, nibble i = bits [4i+3:4i]
blank_mask  in  NUM_DIGITS  bit i = 1 forces digit i dark (sampled live)
lz_suppress  in  1  blank leading zero digits (sampled live)
blink_en  in  1  enable whole-display blink (sampled live)
seg  out  7  segment bus {g,f,e,d,c,b,a}, registered
an  out  NUM_DIGITS  one-hot digit enable, registered
frame_tick  out  1  one-cycle pulse when scan wraps from digit NUM_DIGITS-1 to 0

Behaviour:
- Reset (async, rst_n=0):
  - display register = 0, refresh counter = 0, digit index = 0, frame counter = 0, blink phase = visible.
  - seg = all off, an = all off, frame_tick = 0.
  - Reset mid-scan aborts immediately; no partial slot is resumed.
- Load: on a clk edge with load=1, display register <= data_in. The new value is visible on seg from the next registered update (1-cycle latency).
- Refresh counter: counts 0..REFRESH_DIV-1.
  - At terminal count it returns to 0 and the digit index advances.
  - The index wraps NUM_DIGITS-1 -> 0; at that wrap frame_tick pulses for one cycle, coincident with the index change.
- Blink: frame counter counts frame wraps 0..BLINK_FRAMES-1.
  - At terminal it clears and toggles blink phase. The counter runs regardless of blink_en.
  - When blink_en=1 and phase = hidden, every digit is blanked.
  - blink_en=0 always shows, but the phase keeps toggling.
- Leading-zero suppression: digit i (i>0) is blank when lz_suppress=1 and nibbles NUM_DIGITS-1 down to i are all zero. Digit 0 is never suppressed, so value 0 shows a single "0".
- Blank condition for the current digit = blank_mask[index] OR leading-zero OR blink-hidden.
- Output register, updated every cycle from the current state:
  - an = one-hot at the current index (active level per ACTIVE_LOW), asserted even when the digit is blank.
  - seg = hex pattern of the current nibble, or all-off if blank.
- Hex patterns (active-high, {g..a}):
  - 0=0111111, 1=0000110, 2=1011011, 3=1001111
  - 4=1100110, 5=1101101, 6=1111101, 7=0000111
  - 8=1111111, 9=1101111, A=1110111, b=1111100
  - C=0111001, d=1011110, E=1111001, F=1110001
  - ACTIVE_LOW=1 inverts both seg and an.
- Simultaneous load and slot advance: both take effect; the next digit displays the new data.
- NUM_DIGITS=1: index stays 0, frame_tick pulses every REFRESH_DIV cycles.

Test Plan:
1. Reset, NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1; load 16'h12AF -> an cycles 1110,1101,1011,0111 every 4 clocks; seg = 0001110 (F), 0001000 (A), 0100100 (2), 1111001 (1); frame_tick on each wrap to digit 0.
2. Load 16'h0007, lz_suppress=1 -> digits 3..1 seg=1111111, digit 0 seg=1111000; load 16'h0000 -> digit 0 shows 1000000.
3. blank_mask=4'b0100 with data 16'h8888 -> digit 2 seg=1111111 while an=1011; other digits seg=0000000.
4. BLINK_FRAMES=2, blink_en=1 -> all segs off for frames 2-3, on for frames 4-5; blink_en=0 -> never off.
5. Assert load exactly on the slot-advance edge -> new digit shows the new nibble on the following cycle.
6. Pull rst_n low mid-slot, asynchronously -> seg=1111111 and an=1111 immediately; after release, scan restarts at digit 0 with a full 4-cycle slot.
